// File: rtl/neuron_mac_sequencer.sv
// Time-multiplexed neuron dot product: 32 inputs x 32 weights + bias term through one shared multiplier.
// Latency: accept in cycle T -> out_valid in cycle T+35 (33 issue cycles, 1 drain, then result).
// Backpressure: result held stable in DONE until out_ready; in_ready only in IDLE, no operation overlap.
module neuron_mac_sequencer #(
  parameter int          N_IN    = 32,
  parameter logic [31:0] BIAS_IN = 32'hFFFFFFFE,
  parameter int          ACC_W   = 38
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN-1:0][31:0] in_data,
  input  logic [N_IN:0][31:0]   weight_data,
  output logic [31:0]           mul_a,
  output logic [31:0]           mul_b,
  input  logic [31:0]           mul_p,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic                  busy
);

  localparam int IDX_W = $clog2(N_IN + 1);
  localparam int SEL_W = $clog2(N_IN);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [31:0]           p_q, p_d;
  logic                  p_vld_q, p_vld_d;
  logic [N_IN-1:0][31:0] in_lat_q, in_lat_d;
  logic [N_IN:0][31:0]   w_lat_q, w_lat_d;
  logic [31:0]           out_q, out_d;
  logic [ACC_W-1:0]      p_ext;

  // Clamp the wide accumulator into signed 32-bit range; fits when all bits above bit 31 match bit 31.
  function automatic logic [31:0] sat32(input logic [ACC_W-1:0] v);
    if ((&v[ACC_W-1:31]) || !(|v[ACC_W-1:31])) return v[31:0];
    else if (v[ACC_W-1])                        return 32'h8000_0000;
    else                                        return 32'h7FFF_FFFF;
  endfunction

  // The product register is one cycle behind the issued operands, so it is added a cycle later.
  assign p_ext = {{(ACC_W-32){p_q[31]}}, p_q};

  // Next-state, datapath updates and outputs; every output defaults to its idle value.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    p_d       = p_q;
    p_vld_d   = p_vld_q;
    in_lat_d  = in_lat_q;
    w_lat_d   = w_lat_q;
    out_d     = out_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mul_a     = 32'h0;
    mul_b     = 32'h0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          in_lat_d = in_data;
          w_lat_d  = weight_data;
          acc_d    = '0;
          idx_d    = '0;
          p_vld_d  = 1'b0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mul_a   = (idx_q == IDX_W'(N_IN)) ? BIAS_IN : in_lat_q[idx_q[SEL_W-1:0]];
        mul_b   = w_lat_q[idx_q];
        p_d     = mul_p;
        p_vld_d = 1'b1;
        if (p_vld_q) acc_d = acc_q + p_ext;
        if (idx_q == IDX_W'(N_IN)) state_d = S_DRAIN;
        else                       idx_d   = idx_q + IDX_W'(1);
      end
      S_DRAIN: begin
        acc_d   = acc_q + p_ext;
        p_vld_d = 1'b0;
        out_d   = sat32(acc_d);
        state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      p_q      <= '0;
      p_vld_q  <= 1'b0;
      in_lat_q <= '0;
      w_lat_q  <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      p_q      <= p_d;
      p_vld_q  <= p_vld_d;
      in_lat_q <= in_lat_d;
      w_lat_q  <= w_lat_d;
      out_q    <= out_d;
    end
  end

  assign out_data = out_q;
  assign busy     = (state_q != S_IDLE);

endmodule
